// File: rtl/ucc_pkg.sv
// Shared mode encoding for the universal counter cells and their cascades.
package ucc_pkg;

  typedef enum logic [1:0] {
    UCC_HOLD = 2'b00,
    UCC_UP   = 2'b01,
    UCC_DOWN = 2'b10,
    UCC_LOAD = 2'b11
  } ucc_mode_t;

endpackage

// File: rtl/ucc_next_state_n.sv
// Ripple chain of universal cells: raw next state and raw full-range carry,
// before any modulus, saturation or load-clamp handling.
module ucc_next_state_n
  import ucc_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             cin,
  input  logic [1:0]       m,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] pin,
  output logic [WIDTH-1:0] nxt_raw,
  output logic             carry_raw
);

  logic [WIDTH:0] t;

  // Each cell toggles when its incoming enable is set; the enable ripples on
  // ones for up-count and on zeros for down-count.
  always_comb begin
    t       = '0;
    nxt_raw = q;
    t[0]    = cin & ((m == UCC_UP) | (m == UCC_DOWN));
    for (int i = 0; i < WIDTH; i++) begin
      nxt_raw[i] = q[i] ^ t[i];
      t[i+1]     = t[i] & ((m == UCC_UP) ? q[i] : ~q[i]);
    end
    if (m == UCC_LOAD) begin
      nxt_raw = pin;
    end
    carry_raw = t[WIDTH];
  end

endmodule

// File: rtl/ucc_counter_n.sv
// Registered universal counter (hold/up/down/load) with modulus, optional
// saturation, same-cycle terminal carry for cascading and a wrap pulse.
module ucc_counter_n
  import ucc_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MODULUS  = 16,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cin,
  input  logic [1:0]       m,
  input  logic [WIDTH-1:0] pin,
  output logic [WIDTH-1:0] q,
  output logic             cout,
  output logic [1:0]       mo,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_Q      = WIDTH'(MODULUS - 1);
  localparam bit               FULL_RANGE = (64'(MODULUS) == (64'(1) << WIDTH));

  generate
    if ((WIDTH < 1) || (MODULUS < 2) || (64'(MODULUS) > (64'(1) << WIDTH))) begin : g_bad_param
      $error("ucc_counter_n: illegal WIDTH/MODULUS combination");
    end
  endgenerate

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] nxt_raw;
  logic             carry_raw;
  logic             at_limit;

  ucc_next_state_n #(.WIDTH(WIDTH)) u_cells (
    .cin       (cin),
    .m         (m),
    .q         (q_q),
    .pin       (pin),
    .nxt_raw   (nxt_raw),
    .carry_raw (carry_raw)
  );

  // With a full binary range the cell chain's own carry is the terminal count.
  assign at_limit = ((m == UCC_UP) && (q_q == MAX_Q)) || ((m == UCC_DOWN) && (q_q == '0));
  assign cout     = FULL_RANGE ? carry_raw : (cin & at_limit);
  assign mo       = m;
  assign q        = q_q;
  assign wrap     = wrap_q;

  always_comb begin
    q_d    = nxt_raw;
    wrap_d = cout;
    if (m == UCC_LOAD) begin
      if (pin > MAX_Q) begin
        q_d = MAX_Q;
      end
    end else if (cout) begin
      q_d = SATURATE ? q_q : ((m == UCC_UP) ? '0 : MAX_Q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

endmodule

// File: tb/tb_ucc_counter_n.sv
// Self-checking bench: wrap, saturate and full-binary counters driven in
// parallel against an arithmetic model, plus a two-stage decimal cascade.
module tb_ucc_counter_n;
  import ucc_pkg::*;

  logic       clk = 1'b0;
  logic       rst, cin, ccin;
  logic [1:0] m, cm;
  logic [3:0] pin;

  logic [3:0] q_w   [3];
  logic       cout_w[3];
  logic       wrap_w[3];
  logic [1:0] mo_w  [3];

  logic [3:0] cq0, cq1;
  logic       cc0, cc1, cw0, cw1;
  logic [1:0] cmo0, cmo1;

  int errors = 0;
  int checks = 0;
  int exp_q[3];
  bit exp_w[3];
  int exp_cnt;
  int mods[3] = '{10, 10, 16};
  bit sats[3] = '{1'b0, 1'b1, 1'b0};

  always #5 clk = ~clk;

  ucc_counter_n #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .cin(cin), .m(m), .pin(pin),
    .q(q_w[0]), .cout(cout_w[0]), .mo(mo_w[0]), .wrap(wrap_w[0]));
  ucc_counter_n #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst(rst), .cin(cin), .m(m), .pin(pin),
    .q(q_w[1]), .cout(cout_w[1]), .mo(mo_w[1]), .wrap(wrap_w[1]));
  ucc_counter_n #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b0)) u_bin (
    .clk(clk), .rst(rst), .cin(cin), .m(m), .pin(pin),
    .q(q_w[2]), .cout(cout_w[2]), .mo(mo_w[2]), .wrap(wrap_w[2]));

  ucc_counter_n #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_c0 (
    .clk(clk), .rst(rst), .cin(ccin), .m(cm), .pin(4'h0),
    .q(cq0), .cout(cc0), .mo(cmo0), .wrap(cw0));
  ucc_counter_n #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_c1 (
    .clk(clk), .rst(rst), .cin(cc0), .m(cmo0), .pin(4'h0),
    .q(cq1), .cout(cc1), .mo(cmo1), .wrap(cw1));

  function automatic int model_next(int qv, int mode, bit c, int p, int md, bit s);
    if (mode == 3) return (p > md - 1) ? md - 1 : p;
    if (mode == 1 && c) return (qv == md - 1) ? (s ? qv : 0) : qv + 1;
    if (mode == 2 && c) return (qv == 0) ? (s ? 0 : md - 1) : qv - 1;
    return qv;
  endfunction

  function automatic bit model_cout(int qv, int mode, bit c, int md);
    return c && ((mode == 1 && qv == md - 1) || (mode == 2 && qv == 0));
  endfunction

  task automatic drive(input int mm, input bit c, input int p);
    m = 2'(mm); cin = c; pin = 4'(p);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin exp_q[i] = 0; exp_w[i] = 1'b0; end
    exp_cnt = 0;
  endtask

  // Advance one clock edge and move the reference model with it.
  task automatic tick();
    int nq[3];
    bit nw[3];
    int ncnt;
    for (int i = 0; i < 3; i++) begin
      nq[i] = model_next(exp_q[i], int'(m), cin, int'(pin), mods[i], sats[i]);
      nw[i] = model_cout(exp_q[i], int'(m), cin, mods[i]);
    end
    ncnt = exp_cnt;
    if (ccin && cm == 2'd1) ncnt = (exp_cnt + 1) % 100;
    if (ccin && cm == 2'd2) ncnt = (exp_cnt + 99) % 100;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin exp_q[i] = nq[i]; exp_w[i] = nw[i]; end
    exp_cnt = ncnt;
  endtask

  task automatic test_reset();
    #12;
    for (int i = 0; i < 3; i++) begin
      checks++; if (q_w[i] !== 4'd0) begin errors++; $display("FAIL reset_q[%0d] got %0d want 0", i, q_w[i]); end
      checks++; if (wrap_w[i] !== 1'b0) begin errors++; $display("FAIL reset_wrap[%0d] got %0b want 0", i, wrap_w[i]); end
    end
    rst = 1'b0;
    model_reset();
    drive(1, 1'b1, 0);
    repeat (7) tick();
    checks++; if (q_w[0] !== 4'd7) begin errors++; $display("FAIL count_to_7 got %0d want 7", q_w[0]); end
    #2 rst = 1'b1;
    #1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      checks++; if (q_w[i] !== 4'd0) begin errors++; $display("FAIL async_rst_q[%0d] got %0d want 0", i, q_w[i]); end
      checks++; if (wrap_w[i] !== 1'b0) begin errors++; $display("FAIL async_rst_wrap[%0d] got %0b want 0", i, wrap_w[i]); end
    end
    #1 rst = 1'b0;
    repeat (3) tick();
    checks++; if (q_w[0] !== 4'd3) begin errors++; $display("FAIL after_release got %0d want 3", q_w[0]); end
  endtask

  task automatic test_up_wrap();
    drive(3, 1'b0, 8); tick();
    drive(1, 1'b1, 0);
    checks++; if (cout_w[0] !== 1'b0) begin errors++; $display("FAIL up_cout_at8 got %0b want 0", cout_w[0]); end
    tick();
    checks++; if (q_w[0] !== 4'd9) begin errors++; $display("FAIL up_q9 got %0d want 9", q_w[0]); end
    checks++; if (cout_w[0] !== 1'b1) begin errors++; $display("FAIL up_cout_at9 got %0b want 1", cout_w[0]); end
    tick();
    checks++; if (q_w[0] !== 4'd0) begin errors++; $display("FAIL up_wrap_q got %0d want 0", q_w[0]); end
    checks++; if (wrap_w[0] !== 1'b1) begin errors++; $display("FAIL up_wrap_pulse got %0b want 1", wrap_w[0]); end
    drive(0, 1'b0, 0); tick();
    checks++; if (wrap_w[0] !== 1'b0) begin errors++; $display("FAIL up_wrap_clear got %0b want 0", wrap_w[0]); end
  endtask

  task automatic test_down();
    drive(3, 1'b0, 1); tick();
    drive(2, 1'b1, 0);
    checks++; if (cout_w[0] !== 1'b0) begin errors++; $display("FAIL down_cout_at1 got %0b want 0", cout_w[0]); end
    tick();
    checks++; if (q_w[0] !== 4'd0 || cout_w[0] !== 1'b1) begin errors++; $display("FAIL down_at0 got q=%0d cout=%0b want q=0 cout=1", q_w[0], cout_w[0]); end
    tick();
    checks++; if (q_w[0] !== 4'd9 || wrap_w[0] !== 1'b1) begin errors++; $display("FAIL down_wrap got q=%0d wrap=%0b want q=9 wrap=1", q_w[0], wrap_w[0]); end
    drive(3, 1'b0, 5); tick();
    drive(2, 1'b0, 0);
    checks++; if (cout_w[0] !== 1'b0) begin errors++; $display("FAIL down_cin0_cout got %0b want 0", cout_w[0]); end
    tick();
    checks++; if (q_w[0] !== 4'd5) begin errors++; $display("FAIL down_cin0_hold got %0d want 5", q_w[0]); end
  endtask

  task automatic test_load();
    drive(3, 1'b0, 6); tick();
    checks++; if (q_w[0] !== 4'd6) begin errors++; $display("FAIL load6 got %0d want 6", q_w[0]); end
    drive(3, 1'b1, 13);
    checks++; if (cout_w[0] !== 1'b0) begin errors++; $display("FAIL load_cout got %0b want 0", cout_w[0]); end
    tick();
    checks++; if (q_w[0] !== 4'd9) begin errors++; $display("FAIL load_clamp got %0d want 9", q_w[0]); end
    checks++; if (q_w[2] !== 4'd13) begin errors++; $display("FAIL load_full_range got %0d want 13", q_w[2]); end
  endtask

  task automatic test_saturate();
    drive(3, 1'b0, 9); tick();
    drive(1, 1'b1, 0);
    repeat (3) begin
      checks++; if (cout_w[1] !== 1'b1) begin errors++; $display("FAIL sat_up_cout got %0b want 1", cout_w[1]); end
      tick();
      checks++; if (q_w[1] !== 4'd9 || wrap_w[1] !== 1'b1) begin errors++; $display("FAIL sat_up got q=%0d wrap=%0b want q=9 wrap=1", q_w[1], wrap_w[1]); end
    end
    drive(3, 1'b0, 0); tick();
    drive(2, 1'b1, 0);
    repeat (2) tick();
    checks++; if (q_w[1] !== 4'd0 || wrap_w[1] !== 1'b1) begin errors++; $display("FAIL sat_down got q=%0d wrap=%0b want q=0 wrap=1", q_w[1], wrap_w[1]); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      drive(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
      if ($urandom_range(0, 49) == 0) begin
        rst = 1'b1;
        #1;
        model_reset();
        checks++; if (q_w[0] !== 4'd0 || q_w[1] !== 4'd0 || q_w[2] !== 4'd0) begin errors++; $display("FAIL rand_rst got %0d %0d %0d want 0", q_w[0], q_w[1], q_w[2]); end
        rst = 1'b0;
      end
      for (int i = 0; i < 3; i++) begin
        checks++; if (cout_w[i] !== model_cout(exp_q[i], int'(m), cin, mods[i])) begin errors++; $display("FAIL rand_cout[%0d] got %0b want %0b", i, cout_w[i], model_cout(exp_q[i], int'(m), cin, mods[i])); end
        checks++; if (mo_w[i] !== m) begin errors++; $display("FAIL rand_mo[%0d] got %0d want %0d", i, mo_w[i], m); end
      end
      tick();
      for (int i = 0; i < 3; i++) begin
        checks++; if (q_w[i] !== 4'(exp_q[i])) begin errors++; $display("FAIL rand_q[%0d] got %0d want %0d", i, q_w[i], exp_q[i]); end
        checks++; if (wrap_w[i] !== exp_w[i]) begin errors++; $display("FAIL rand_wrap[%0d] got %0b want %0b", i, wrap_w[i], exp_w[i]); end
      end
    end
  endtask

  task automatic test_cascade();
    drive(0, 1'b0, 0);
    rst = 1'b1; #1; model_reset(); rst = 1'b0;
    cm = 2'd1; ccin = 1'b1;
    repeat (25) tick();
    checks++; if (cq1 !== 4'd2 || cq0 !== 4'd5) begin errors++; $display("FAIL cascade_25 got %0d%0d want 25", cq1, cq0); end
    for (int n = 0; n < 200; n++) begin
      cm = 2'($urandom_range(0, 2)); ccin = 1'($urandom_range(0, 1));
      #1;
      checks++; if (cc1 !== (ccin && ((cm == 2'd1 && exp_cnt == 99) || (cm == 2'd2 && exp_cnt == 0)))) begin errors++; $display("FAIL cascade_cout got %0b at count %0d", cc1, exp_cnt); end
      tick();
      checks++; if (cq1 !== 4'(exp_cnt / 10) || cq0 !== 4'(exp_cnt % 10)) begin errors++; $display("FAIL cascade_count got %0d%0d want %0d", cq1, cq0, exp_cnt); end
    end
    ccin = 1'b0; cm = 2'd0;
  endtask

  initial begin
    rst = 1'b1; cin = 1'b0; m = 2'd0; pin = 4'd0; ccin = 1'b0; cm = 2'd0;
    model_reset();
    test_reset();
    test_up_wrap();
    test_down();
    test_load();
    test_saturate();
    test_random();
    test_cascade();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
